mesh_mix_seq: RTL and testbench
===============================

MESH_MIX_SEQ -- requirements
Module: mesh_mix_seq

Interface
REQ-001 Parameter N_CH, default 2: number of fluid inlet/outlet channels; legal range 1 or more.
REQ-002 Parameter N_STAGE, default 2: number of diffusion-mix mesh stages; legal range 2 or more.
REQ-003 Parameter DWELL_W, default 8: width of the dwell-time operand.
REQ-004 Parameter REP_W, default 4: width of the recirculation-repeat operand.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  run request; sampled only in IDLE.
REQ-008 mode  input  1  0 = single feed-forward pass; 1 = recirculating passes.
REQ-009 dwell  input  DWELL_W  cycles per phase; latched at accepted start.
REQ-010 reps  input  REP_W  extra passes in mode 1; latched at accepted start.
REQ-011 abort  input  1  terminate the run immediately.
REQ-012 inlet_valve  output  N_CH  open all inlets during FILL.
REQ-013 stage_valve  output  N_STAGE  one-hot open enable of the active mix stage.
REQ-014 outlet_valve  output  N_CH  open all outlets during FLUSH.
REQ-015 stage_idx  output  clog2(N_STAGE)  index of the active stage; 0 outside MIX.
REQ-016 busy  output  1  high in FILL, MIX and FLUSH.
REQ-017 done  output  1  one-cycle pulse on normal completion.
REQ-018 aborted  output  1  one-cycle pulse when an active run is aborted.

Function
REQ-019 FSM states: IDLE, FILL, MIX, FLUSH and DONE.
REQ-020 In IDLE, start=1 with abort=0 latches dwell, reps and mode, then enters FILL on the next edge.
REQ-021 A latched dwell of 0 is treated as 1.
REQ-022 Every phase (FILL, each MIX stage, FLUSH) lasts exactly the latched dwell cycles.
REQ-023 FILL drives inlet_valve all ones, then enters MIX at stage N_STAGE-1.
REQ-024 MIX steps from stage N_STAGE-1 down to stage 0, with stage_valve bit k set only while stage k is active.
REQ-025 After stage 0: if mode=1 and the pass counter is below reps, the counter increments and MIX restarts at stage N_STAGE-1; otherwise the FSM enters FLUSH.
REQ-026 Total passes equal reps+1 in mode 1 and 1 in mode 0; reps=0 in mode 1 gives a single pass.
REQ-027 FLUSH drives outlet_valve all ones, then enters DONE.
REQ-028 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-029 All outputs are registered, and at most one of the three valve groups is nonzero in any cycle.
REQ-030 start asserted outside IDLE is ignored, and operands are not re-latched.
REQ-031 abort=1 in FILL, MIX or FLUSH: on the next edge all valves go to 0, busy=0, aborted=1 for one cycle, the state returns to IDLE and done is not pulsed.
REQ-032 abort in IDLE or DONE has no effect: aborted stays 0, and in DONE the done pulse still completes.
REQ-033 abort together with start in IDLE: abort wins, the run is not started and no pulse is produced.
REQ-034 Input changes to dwell, reps or mode during a run do not affect that run.

Reset
REQ-035 rst_n=0 asynchronously forces IDLE, all valves 0, stage_idx 0, busy 0, done 0, aborted 0, and clears all counters.
REQ-036 Reset in the middle of a run discards the run, and no done or aborted pulse follows release.
REQ-037 After rst_n deassertion, the first start can be accepted on the first clock edge.

Structure
REQ-038 Package mesh_seq_pkg holds the state enumeration and the default parameter constants.
REQ-039 Sub-module dwell_timer, a loadable down-counter with an expire flag, times every phase and is instantiated once.

Verification
REQ-040 Test: N_CH=2, N_STAGE=2, mode=0, dwell=3, start pulsed at cycle 0. Required: inlet open cycles 1-3, stage_valve 10 in cycles 4-6, stage_valve 01 in cycles 7-9, outlet open cycles 10-12, done=1 in cycle 13 only.
REQ-041 Test: mode=1, reps=2, dwell=3. Required: 3 passes with 18 MIX cycles total, done in cycle 25.
REQ-042 Test: dwell=0, mode=0. Required: each phase lasts 1 cycle, done in cycle 5.
REQ-043 Test: abort asserted in cycle 8 of the REQ-040 run. Required: in cycle 9 all valves 0, busy 0 and aborted 1; done never asserts.
REQ-044 Test: start re-pulsed in cycle 5 with dwell=7. Required: timing is identical to REQ-040.
REQ-045 Test: rst_n low in cycle 6 of the REQ-040 run. Required: outputs clear immediately and no pulses follow release.

Source files
------------

// File: rtl/mesh_seq_pkg.sv
// ============================================================================
// Module : mesh_seq_pkg
// Brief  : Shared state enumeration and default parameters for the mesh mixer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mesh_seq_pkg;

  localparam int unsigned N_CH_DEF    = 2;
  localparam int unsigned N_STAGE_DEF = 2;
  localparam int unsigned DWELL_W_DEF = 8;
  localparam int unsigned REP_W_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_MIX   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
// Module : dwell_timer
// Brief  : Loadable down-counter; expired_o is high once the count reaches 0.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dwell_timer
  import mesh_seq_pkg::*;
#(
  parameter int W = DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mesh_mix_seq.sv
// ============================================================================
// Module : mesh_mix_seq
// Brief  : Fill / multi-stage mix / flush valve sequencer with recirculation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mesh_mix_seq
  import mesh_seq_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int N_STAGE = N_STAGE_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int REP_W   = REP_W_DEF,
  localparam int SW     = $clog2(N_STAGE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [REP_W-1:0]   reps_i,
  input  logic               abort_i,
  output logic [N_CH-1:0]    inlet_valve_o,
  output logic [N_STAGE-1:0] stage_valve_o,
  output logic [N_CH-1:0]    outlet_valve_o,
  output logic [SW-1:0]      stage_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o
);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [REP_W-1:0]   pass_q, pass_d;
  logic               mode_q, mode_d;
  logic [SW-1:0]      stage_q, stage_d;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_exp;
  logic               abort_evt;
  logic [DWELL_W-1:0] dwell_in_eff;

  logic [N_CH-1:0]    inlet_d, outlet_d;
  logic [N_STAGE-1:0] stage_valve_d;
  logic [SW-1:0]      stage_idx_d;
  logic               busy_d, done_d, aborted_d;

  assign dwell_in_eff = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;

  // Timer holds (dwell - 1) at phase entry so each phase lasts dwell cycles.
  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    reps_d    = reps_q;
    mode_d    = mode_q;
    pass_d    = pass_q;
    stage_d   = stage_q;
    tmr_load  = 1'b0;
    abort_evt = 1'b0;
    tmr_val   = (state_q == ST_IDLE) ? (dwell_in_eff - DWELL_W'(1))
                                     : (dwell_q - DWELL_W'(1));
    if (abort_i && (state_q == ST_FILL || state_q == ST_MIX || state_q == ST_FLUSH)) begin
      state_d   = ST_IDLE;
      abort_evt = 1'b1;
      pass_d    = '0;
      stage_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state_d  = ST_FILL;
            dwell_d  = dwell_in_eff;
            reps_d   = reps_i;
            mode_d   = mode_i;
            pass_d   = '0;
            tmr_load = 1'b1;
          end
        end
        ST_FILL: begin
          if (tmr_exp) begin
            state_d  = ST_MIX;
            stage_d  = SW'(N_STAGE - 1);
            tmr_load = 1'b1;
          end
        end
        ST_MIX: begin
          if (tmr_exp) begin
            tmr_load = 1'b1;
            if (stage_q != '0) begin
              stage_d = stage_q - SW'(1);
            end else if (mode_q && (pass_q < reps_q)) begin
              pass_d  = pass_q + REP_W'(1);
              stage_d = SW'(N_STAGE - 1);
            end else begin
              state_d = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (tmr_exp) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          pass_d  = '0;
          stage_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    inlet_d       = (state_d == ST_FILL)  ? '1 : '0;
    outlet_d      = (state_d == ST_FLUSH) ? '1 : '0;
    stage_idx_d   = (state_d == ST_MIX)   ? stage_d : '0;
    stage_valve_d = '0;
    for (int k = 0; k < N_STAGE; k++) begin
      stage_valve_d[k] = (state_d == ST_MIX) && (stage_d == SW'(k));
    end
    busy_d    = (state_d == ST_FILL) || (state_d == ST_MIX) || (state_d == ST_FLUSH);
    done_d    = (state_d == ST_DONE);
    aborted_d = abort_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      dwell_q        <= DWELL_W'(1);
      reps_q         <= '0;
      mode_q         <= 1'b0;
      pass_q         <= '0;
      stage_q        <= '0;
      inlet_valve_o  <= '0;
      stage_valve_o  <= '0;
      outlet_valve_o <= '0;
      stage_idx_o    <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      aborted_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      reps_q         <= reps_d;
      mode_q         <= mode_d;
      pass_q         <= pass_d;
      stage_q        <= stage_d;
      inlet_valve_o  <= inlet_d;
      stage_valve_o  <= stage_valve_d;
      outlet_valve_o <= outlet_d;
      stage_idx_o    <= stage_idx_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      aborted_o      <= aborted_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mesh_mix_seq.sv
// ============================================================================
// Module : tb_mesh_mix_seq
// Brief  : Self-checking bench for mesh_mix_seq against a per-cycle trace model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mesh_mix_seq;

  localparam int N_CH    = 2;
  localparam int N_STAGE = 2;
  localparam int DWELL_W = 8;
  localparam int REP_W   = 4;
  localparam int SW      = $clog2(N_STAGE);
  localparam int VW      = 2 * N_CH + N_STAGE + SW + 3;

  logic               clk;
  logic               rst_n;
  logic               start_i;
  logic               mode_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [REP_W-1:0]   reps_i;
  logic               abort_i;
  logic [N_CH-1:0]    inlet_valve_o;
  logic [N_STAGE-1:0] stage_valve_o;
  logic [N_CH-1:0]    outlet_valve_o;
  logic [SW-1:0]      stage_idx_o;
  logic               busy_o;
  logic               done_o;
  logic               aborted_o;

  int n_vec = 0;
  int n_err = 0;

  logic [VW-1:0] exp_q[$];
  bit            act_q[$];
  bit            bsy_q[$];

  mesh_mix_seq #(
    .N_CH(N_CH), .N_STAGE(N_STAGE), .DWELL_W(DWELL_W), .REP_W(REP_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .dwell_i        (dwell_i),
    .reps_i         (reps_i),
    .abort_i        (abort_i),
    .inlet_valve_o  (inlet_valve_o),
    .stage_valve_o  (stage_valve_o),
    .outlet_valve_o (outlet_valve_o),
    .stage_idx_o    (stage_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .aborted_o      (aborted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {inlet_valve_o, stage_valve_o, stage_idx_o, outlet_valve_o, busy_o, done_o, aborted_o};
  endfunction

  // Expected output word for one cycle; stage < 0 means no mix stage open.
  function automatic logic [VW-1:0] mk(bit inl, int stage, bit outl, bit dn, bit ab);
    logic [N_CH-1:0]    vi;
    logic [N_CH-1:0]    vo;
    logic [N_STAGE-1:0] vs;
    logic [SW-1:0]      ix;
    vi = inl  ? {N_CH{1'b1}} : '0;
    vo = outl ? {N_CH{1'b1}} : '0;
    vs = '0;
    ix = '0;
    if (stage >= 0) begin
      vs[stage] = 1'b1;
      ix = SW'(stage);
    end
    return {vi, vs, ix, vo, (inl || outl || stage >= 0), dn, ab};
  endfunction

  function automatic void push(logic [VW-1:0] v, bit act, bit bsy);
    exp_q.push_back(v);
    act_q.push_back(act);
    bsy_q.push_back(bsy);
  endfunction

  // Model: list every cycle of the run from the phase rules, then cut at abort.
  function automatic void build(bit m, int d, int r, int abort_at);
    int dd;
    int passes;
    exp_q.delete(); act_q.delete(); bsy_q.delete();
    dd     = (d == 0) ? 1 : d;
    passes = m ? r + 1 : 1;
    for (int i = 0; i < dd; i++) push(mk(1, -1, 0, 0, 0), 1, 1);
    for (int p = 0; p < passes; p++)
      for (int s = N_STAGE - 1; s >= 0; s--)
        for (int i = 0; i < dd; i++) push(mk(0, s, 0, 0, 0), 1, 1);
    for (int i = 0; i < dd; i++) push(mk(0, -1, 1, 0, 0), 1, 1);
    push(mk(0, -1, 0, 1, 0), 1, 0);
    for (int i = 0; i < 2; i++) push(mk(0, -1, 0, 0, 0), 0, 0);
    if (abort_at >= 1 && abort_at <= exp_q.size() && bsy_q[abort_at-1]) begin
      while (exp_q.size() > abort_at) begin
        void'(exp_q.pop_back());
        void'(act_q.pop_back());
        void'(bsy_q.pop_back());
      end
      push(mk(0, -1, 0, 0, 1), 0, 0);
      for (int i = 0; i < 2; i++) push(mk(0, -1, 0, 0, 0), 0, 0);
    end
  endfunction

  // Cycle 0 is the current cycle (start driven now); cycle c follows edge c.
  task automatic run_check(input string nm, input bit m, input int d, input int r,
                           input int abort_at, input int restart_at, input bit noise);
    logic [VW-1:0] got;
    build(m, d, r, abort_at);
    mode_i  = m;
    dwell_i = DWELL_W'(d);
    reps_i  = REP_W'(r);
    abort_i = 1'b0;
    start_i = 1'b1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      if (noise) begin
        dwell_i = DWELL_W'($urandom);
        reps_i  = REP_W'($urandom);
        mode_i  = 1'($urandom);
      end
      got = dut_vec();
      n_vec++;
      if (got !== exp_q[c-1]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b expected %b", nm, c, got, exp_q[c-1]);
      end
      if (c == abort_at) abort_i = 1'b1;
      if (c == restart_at) begin
        start_i = 1'b1;
        dwell_i = DWELL_W'(7);
      end
      if (noise && act_q[c-1] && $urandom_range(0, 3) == 0) start_i = 1'b1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic check_idle(input string nm, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (dut_vec() !== '0) begin
        n_err++;
        $display("FAIL %s idle cycle %0d: got %b expected all zero", nm, c, dut_vec());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; dwell_i = '0; reps_i = '0; abort_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (dut_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected all zero", dut_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass();
    run_check("single_pass", 1'b0, 3, 0, -1, -1, 1'b0);
  endtask

  task automatic test_recirc();
    int mix_cycles;
    run_check("recirc", 1'b1, 3, 2, -1, -1, 1'b0);
    mix_cycles = 0;
    foreach (exp_q[i]) if (exp_q[i][VW-N_CH-1 -: N_STAGE] != '0) mix_cycles++;
    n_vec++;
    if (mix_cycles != 18 || exp_q[24] !== mk(0, -1, 0, 1, 0)) begin
      n_err++;
      $display("FAIL recirc_model: mix cycles %0d expected 18", mix_cycles);
    end
  endtask

  task automatic test_dwell_zero();
    run_check("dwell_zero", 1'b0, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    run_check("abort_mix", 1'b0, 3, 0, 8, -1, 1'b0);
    run_check("abort_fill", 1'b1, 2, 1, 1, -1, 1'b0);
  endtask

  task automatic test_abort_done();
    run_check("abort_in_done", 1'b0, 0, 0, 5, -1, 1'b0);
  endtask

  task automatic test_abort_idle();
    abort_i = 1'b1;
    check_idle("abort_idle", 3);
    start_i = 1'b1;
    dwell_i = DWELL_W'(3);
    check_idle("abort_with_start", 3);
    start_i = 1'b0;
    abort_i = 1'b0;
    check_idle("abort_release", 1);
  endtask

  task automatic test_restart_ignored();
    run_check("restart_ignored", 1'b0, 3, 0, -1, 5, 1'b0);
  endtask

  task automatic test_reset_midrun();
    mode_i = 1'b0; dwell_i = DWELL_W'(3); reps_i = '0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dut_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_midrun_immediate: got %b expected all zero", dut_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset_midrun_after", 20);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_check("start_after_reset", 1'b1, 1, 1, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1;
      run_check("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), ab, -1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_recirc();
    test_dwell_zero();
    test_abort();
    test_abort_done();
    test_abort_idle();
    test_restart_ignored();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
